// File: rtl/bus_master_ctrl.sv
// ---------------------------------------------------------------------------
// bus_master_ctrl
//
// Single-outstanding bus initiator. Accepts one command at a time on a
// valid/ready handshake, drives a strobe-qualified bus cycle, waits for the
// responder's ACK and reports completion on a one-cycle response pulse.
// All outputs are registered.
//
// Optional feature macro: BUS_MASTER_TIMEOUT_EN
//   defined     -> bus cycles are aborted after TIMEOUT_CYC cycles without
//                  ACK; the response carries ERR_RDATA and oRspErr=1.
//   not defined -> BUS waits for ACK indefinitely; oRspErr is tied low.
//
// Parameters
//   TIMEOUT_CYC  cycles a bus cycle may wait for iACK (2..65535)
//   ERR_RDATA    response data returned on an aborted cycle
//
// Ports
//   iCLK, iRSTn           clock, synchronous active-low reset
//   iCmdValid/oCmdReady   command handshake
//   iCmdWe/Adr/Dat/Sel    command fields (write flag, address, data, lanes)
//   oRspValid/Dat/Err     one-cycle response pulse, read data, abort flag
//   oADR/oDAT/oSEL/oWE    bus address, write data, byte selects, write enable
//   oSTB/oCYC             bus strobe and cycle qualifiers
//   iDAT/iACK             bus read data and acknowledge
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bus_master_ctrl #(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdWe,
  input  logic [31:0] iCmdAdr,
  input  logic [31:0] iCmdDat,
  input  logic [3:0]  iCmdSel,
  output logic        oRspValid,
  output logic [31:0] oRspDat,
  output logic        oRspErr,
  output logic [31:0] oADR,
  output logic [31:0] oDAT,
  output logic [3:0]  oSEL,
  output logic        oWE,
  output logic        oSTB,
  output logic        oCYC,
  input  logic [31:0] iDAT,
  input  logic        iACK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

`ifdef BUS_MASTER_TIMEOUT_EN
  // Counter value seen on the edge where the cycle must be aborted: the
  // counter reads 0 on the first BUS edge, so abort lands TIMEOUT_CYC edges
  // after the accept edge.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tmo_cnt;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state     <= IDLE;
      oCmdReady <= 1'b1;
      oRspValid <= 1'b0;
      oRspDat   <= 32'h0;
      oRspErr   <= 1'b0;
      oADR      <= 32'h0;
      oDAT      <= 32'h0;
      oSEL      <= 4'h0;
      oWE       <= 1'b0;
      oSTB      <= 1'b0;
      oCYC      <= 1'b0;
      tmo_cnt   <= 16'h0;
    end else begin
      oRspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iCmdValid && oCmdReady) begin
            oADR      <= iCmdAdr;
            oDAT      <= iCmdDat;
            oSEL      <= iCmdSel;
            oWE       <= iCmdWe;
            oSTB      <= 1'b1;
            oCYC      <= 1'b1;
            oCmdReady <= 1'b0;
            tmo_cnt   <= 16'h0;
            state     <= BUS;
          end
        end
        BUS: begin
          // ACK is checked first so it wins over a coincident expiry.
          if (iACK) begin
            oSTB      <= 1'b0;
            oCYC      <= 1'b0;
            oRspDat   <= oWE ? 32'h0 : iDAT;
            oRspErr   <= 1'b0;
            oRspValid <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            oSTB      <= 1'b0;
            oCYC      <= 1'b0;
            oRspDat   <= ERR_RDATA;
            oRspErr   <= 1'b1;
            oRspValid <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt != 16'hFFFF) begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        RESP: begin
          oCmdReady <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          oSTB      <= 1'b0;
          oCYC      <= 1'b0;
          oCmdReady <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
`else
  // Abort path absent: the configuration parameters have no consumer.
  logic unused_cfg;
  assign unused_cfg = ^{ERR_RDATA, TIMEOUT_CYC[0]};

  assign oRspErr = 1'b0;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state     <= IDLE;
      oCmdReady <= 1'b1;
      oRspValid <= 1'b0;
      oRspDat   <= 32'h0;
      oADR      <= 32'h0;
      oDAT      <= 32'h0;
      oSEL      <= 4'h0;
      oWE       <= 1'b0;
      oSTB      <= 1'b0;
      oCYC      <= 1'b0;
    end else begin
      oRspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iCmdValid && oCmdReady) begin
            oADR      <= iCmdAdr;
            oDAT      <= iCmdDat;
            oSEL      <= iCmdSel;
            oWE       <= iCmdWe;
            oSTB      <= 1'b1;
            oCYC      <= 1'b1;
            oCmdReady <= 1'b0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (iACK) begin
            oSTB      <= 1'b0;
            oCYC      <= 1'b0;
            oRspDat   <= oWE ? 32'h0 : iDAT;
            oRspValid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          oCmdReady <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          oSTB      <= 1'b0;
          oCYC      <= 1'b0;
          oCmdReady <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_master_ctrl
//
// Directed bench for bus_master_ctrl. The driver issues commands and plays
// the responder; every command expected to complete pushes its response
// into a queue, and an independent monitor pops and compares whenever
// oRspValid is seen. Timeout scenarios follow BUS_MASTER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bus_master_ctrl;

  localparam int          TIMEOUT_CYC = 16;
  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

  logic        iCLK;
  logic        iRSTn;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWe;
  logic [31:0] iCmdAdr;
  logic [31:0] iCmdDat;
  logic [3:0]  iCmdSel;
  logic        oRspValid;
  logic [31:0] oRspDat;
  logic        oRspErr;
  logic [31:0] oADR;
  logic [31:0] oDAT;
  logic [3:0]  oSEL;
  logic        oWE;
  logic        oSTB;
  logic        oCYC;
  logic [31:0] iDAT;
  logic        iACK;

  bus_master_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ERR_RDATA   (ERR_RDATA)
  ) dut (
    .iCLK      (iCLK),
    .iRSTn     (iRSTn),
    .iCmdValid (iCmdValid),
    .oCmdReady (oCmdReady),
    .iCmdWe    (iCmdWe),
    .iCmdAdr   (iCmdAdr),
    .iCmdDat   (iCmdDat),
    .iCmdSel   (iCmdSel),
    .oRspValid (oRspValid),
    .oRspDat   (oRspDat),
    .oRspErr   (oRspErr),
    .oADR      (oADR),
    .oDAT      (oDAT),
    .oSEL      (oSEL),
    .oWE       (oWE),
    .oSTB      (oSTB),
    .oCYC      (oCYC),
    .iDAT      (iDAT),
    .iACK      (iACK)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] exp_dat_q[$];
  logic        exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_rsp(input logic [31:0] dat, input logic err);
    exp_dat_q.push_back(dat);
    exp_err_q.push_back(err);
  endtask

  // Response monitor: one pop per cycle that oRspValid is high.
  initial begin
    logic [31:0] d;
    logic        e;
    forever begin
      @(negedge iCLK);
      if (iRSTn === 1'b1 && oRspValid === 1'b1) begin
        if (exp_dat_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_rsp: got oRspValid=1 dat=%h err=%b expected no response (t=%0t)",
                   oRspDat, oRspErr, $time);
        end else begin
          d = exp_dat_q.pop_front();
          e = exp_err_q.pop_front();
          check("rsp_dat", oRspDat, d);
          check("rsp_err", {31'h0, oRspErr}, {31'h0, e});
        end
      end
    end
  end

  // Wait for ready, present the command for one accept edge, then scramble
  // the command inputs to show they no longer affect the bus.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    iCmdWe    = we;
    iCmdAdr   = adr;
    iCmdDat   = dat;
    iCmdSel   = sel;
    iCmdValid = 1'b1;
    for (int i = 0; i < 20 && oCmdReady !== 1'b1; i++) begin
      @(posedge iCLK);
      #1;
    end
    check("cmd_ready_before_accept", {31'h0, oCmdReady}, 32'h1);
    @(posedge iCLK);
    #1;
    iCmdValid = 1'b0;
    iCmdWe    = ~we;
    iCmdAdr   = ~adr;
    iCmdDat   = ~dat;
    iCmdSel   = ~sel;
    check("accept_stb", {31'h0, oSTB}, 32'h1);
    check("accept_cyc", {31'h0, oCYC}, 32'h1);
    check("accept_adr", oADR, adr);
    check("accept_dat", oDAT, dat);
    check("accept_sel", {28'h0, oSEL}, {28'h0, sel});
    check("accept_we", {31'h0, oWE}, {31'h0, we});
    check("accept_ready_low", {31'h0, oCmdReady}, 32'h0);
  endtask

  // Hold ACK low for 'waits' edges, then ACK on the next edge.
  task automatic respond(input int waits, input logic [31:0] rdata, input logic [31:0] adr_exp,
                         input logic [31:0] dat_exp);
    for (int i = 0; i < waits; i++) begin
      @(posedge iCLK);
      #1;
      check("wait_stb_held", {31'h0, oSTB}, 32'h1);
      check("wait_adr_held", oADR, adr_exp);
      check("wait_dat_held", oDAT, dat_exp);
    end
    iACK = 1'b1;
    iDAT = rdata;
    @(posedge iCLK);
    #1;
    iACK = 1'b0;
    iDAT = 32'h0BAD_F00D;
    check("ack_stb_low", {31'h0, oSTB}, 32'h0);
    check("ack_cyc_low", {31'h0, oCYC}, 32'h0);
    check("ack_rsp_valid", {31'h0, oRspValid}, 32'h1);
    check("ack_adr_retained", oADR, adr_exp);
    @(posedge iCLK);
    #1;
    check("post_rsp_valid_low", {31'h0, oRspValid}, 32'h0);
    check("post_rsp_ready", {31'h0, oCmdReady}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        stb_all_high;
    logic        stb_prev;
    int          acc_cnt;
    int          last_acc;
    logic        b2b_we  [4];
    logic [31:0] b2b_adr [4];
    logic [31:0] b2b_dat [4];
    logic [31:0] b2b_rd  [4];

    iRSTn     = 1'b0;
    iCmdValid = 1'b0;
    iCmdWe    = 1'b0;
    iCmdAdr   = 32'h0;
    iCmdDat   = 32'h0;
    iCmdSel   = 4'h0;
    iDAT      = 32'h0;
    iACK      = 1'b0;

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_ready", {31'h0, oCmdReady}, 32'h1);
    check("rst_stb", {31'h0, oSTB}, 32'h0);
    check("rst_cyc", {31'h0, oCYC}, 32'h0);
    check("rst_we", {31'h0, oWE}, 32'h0);
    check("rst_adr", oADR, 32'h0);
    check("rst_dat", oDAT, 32'h0);
    check("rst_sel", {28'h0, oSEL}, 32'h0);
    check("rst_rsp_valid", {31'h0, oRspValid}, 32'h0);
    check("rst_rsp_dat", oRspDat, 32'h0);
    check("rst_rsp_err", {31'h0, oRspErr}, 32'h0);
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;

    // Write, one wait cycle
    expect_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h0200_0104, 32'hA5A5_0001, 4'hF);
    respond(1, 32'h1234_5678, 32'h0200_0104, 32'hA5A5_0001);

    // Read, three wait cycles: oSTB high for exactly four cycles
    expect_rsp(32'h0000_00C3, 1'b0);
    issue(1'b0, 32'h0200_0800, 32'h0, 4'hF);
    respond(3, 32'h0000_00C3, 32'h0200_0800, 32'h0);

    // Unmapped read, no ACK
`ifdef BUS_MASTER_TIMEOUT_EN
    expect_rsp(ERR_RDATA, 1'b1);
    issue(1'b0, 32'h0300_0000, 32'h0, 4'hF);
    stb_all_high = 1'b1;
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      @(posedge iCLK);
      #1;
      if (oSTB !== 1'b1) stb_all_high = 1'b0;
    end
    check("tmo_stb_held", {31'h0, stb_all_high}, 32'h1);
    @(posedge iCLK);
    #1;
    check("tmo_stb_drop", {31'h0, oSTB}, 32'h0);
    check("tmo_cyc_drop", {31'h0, oCYC}, 32'h0);
    check("tmo_rsp_valid", {31'h0, oRspValid}, 32'h1);
    check("tmo_rsp_err_now", {31'h0, oRspErr}, 32'h1);
    @(posedge iCLK);
    #1;
    check("tmo_ready_back", {31'h0, oCmdReady}, 32'h1);
`else
    expect_rsp(32'h0000_0077, 1'b0);
    issue(1'b0, 32'h0300_0000, 32'h0, 4'hF);
    stb_all_high = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge iCLK);
      #1;
      if (oSTB !== 1'b1 || oCYC !== 1'b1) stb_all_high = 1'b0;
    end
    check("notmo_stb_held_120", {31'h0, stb_all_high}, 32'h1);
    respond(0, 32'h0000_0077, 32'h0300_0000, 32'h0);
`endif

    // ACK on the exact timeout edge: normal completion
    expect_rsp(32'h0000_005A, 1'b0);
    issue(1'b0, 32'h0200_0804, 32'h0, 4'h1);
    respond(TIMEOUT_CYC - 1, 32'h0000_005A, 32'h0200_0804, 32'h0);

    // Reset during BUS: no response for the dropped command
    issue(1'b0, 32'h0200_0808, 32'h0, 4'hF);
    @(posedge iCLK);
    #1;
    iRSTn = 1'b0;
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    check("midrst_stb", {31'h0, oSTB}, 32'h0);
    check("midrst_cyc", {31'h0, oCYC}, 32'h0);
    check("midrst_ready", {31'h0, oCmdReady}, 32'h1);
    check("midrst_rsp_valid", {31'h0, oRspValid}, 32'h0);
    check("midrst_adr", oADR, 32'h0);
    repeat (3) @(posedge iCLK);
    #1;
    expect_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h0200_0000, 32'h0000_0003, 4'h1);
    respond(0, 32'h0, 32'h0200_0000, 32'h0000_0003);

    // Back-to-back with iCmdValid and iACK held high
    b2b_we[0] = 1'b0; b2b_adr[0] = 32'h0200_0800; b2b_dat[0] = 32'h0;         b2b_rd[0] = 32'h0000_0011;
    b2b_we[1] = 1'b1; b2b_adr[1] = 32'h0200_0104; b2b_dat[1] = 32'h1111_2222; b2b_rd[1] = 32'hFFFF_FFFF;
    b2b_we[2] = 1'b0; b2b_adr[2] = 32'h0200_0808; b2b_dat[2] = 32'h0;         b2b_rd[2] = 32'h8000_0001;
    b2b_we[3] = 1'b1; b2b_adr[3] = 32'h0200_0000; b2b_dat[3] = 32'h0000_00FF; b2b_rd[3] = 32'h5555_AAAA;
    iCmdWe    = b2b_we[0];
    iCmdAdr   = b2b_adr[0];
    iCmdDat   = b2b_dat[0];
    iCmdSel   = 4'hF;
    iDAT      = b2b_rd[0];
    iACK      = 1'b1;
    iCmdValid = 1'b1;
    stb_prev  = 1'b0;
    acc_cnt   = 0;
    last_acc  = 0;
    for (int cyc = 1; cyc <= 40 && acc_cnt < 4; cyc++) begin
      @(posedge iCLK);
      #1;
      if (oSTB === 1'b1 && stb_prev !== 1'b1) begin
        check("b2b_adr", oADR, b2b_adr[acc_cnt]);
        check("b2b_we", {31'h0, oWE}, {31'h0, b2b_we[acc_cnt]});
        if (acc_cnt > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd3);
        expect_rsp(b2b_we[acc_cnt] ? 32'h0 : b2b_rd[acc_cnt], 1'b0);
        iDAT     = b2b_rd[acc_cnt];
        last_acc = cyc;
        acc_cnt++;
        if (acc_cnt < 4) begin
          iCmdWe  = b2b_we[acc_cnt];
          iCmdAdr = b2b_adr[acc_cnt];
          iCmdDat = b2b_dat[acc_cnt];
        end else begin
          iCmdValid = 1'b0;
        end
      end
      stb_prev = oSTB;
    end
    check("b2b_accept_count", 32'(acc_cnt), 32'd4);

    // Spurious ACK while idle: bus stays quiet
    repeat (5) @(posedge iCLK);
    #1;
    check("idle_ack_stb", {31'h0, oSTB}, 32'h0);
    check("idle_ack_ready", {31'h0, oCmdReady}, 32'h1);
    iACK = 1'b0;

    repeat (3) @(posedge iCLK);
    #1;
    check("rsp_queue_drained", 32'(exp_dat_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_master_ctrl.md
# bus_master_ctrl

Single-outstanding bus initiator that turns a simple command/response handshake into strobe-qualified bus cycles (address, write data, byte selects, WE, STB, CYC) and waits for the addressed responder's ACK. Sits between the CPU-side command source and the address decoder / peripheral fabric (control register, digital output port, digital input port). It registers every bus output, captures read data, and reports completion or timeout on a one-cycle response pulse.

## Interface
- TIMEOUT_CYC, 16: cycles a bus cycle may wait for iACK before being aborted; legal range 2..65535
- ERR_RDATA, 32'h0000_0000: value returned on oRspDat when a cycle is aborted
- iCLK  in  1  clock; all logic on rising edge
- iRSTn  in  1  synchronous, active-low reset
- iCmdValid  in  1  command present
- oCmdReady  out  1  block can accept a command
- iCmdWe  in  1  1 = write, 0 = read
- iCmdAdr  in  32  byte address
- iCmdDat  in  32  write data
- iCmdSel  in  4  byte-lane selects
- oRspValid  out  1  one-cycle completion pulse
- oRspDat  out  32  read data (0 for writes, ERR_RDATA on abort)
- oRspErr  out  1  1 = cycle aborted by timeout; valid with oRspValid
- oADR  out  32  bus address
- oDAT  out  32  bus write data
- oSEL  out  4  bus byte selects
- oWE  out  1  bus write enable
- oSTB  out  1  bus strobe (feeds the address decoder)
- oCYC  out  1  bus cycle in progress
- iDAT  in  32  bus read data
- iACK  in  1  bus acknowledge from the selected responder

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: oCmdReady=1. iCmdValid & oCmdReady at an edge = accept; latch iCmdAdr/Dat/Sel/We into oADR/oDAT/oSEL/oWE; set oSTB=oCYC=1; clear timeout counter; go BUS.
- BUS: oCmdReady=0; bus outputs held stable. On an edge with iACK=1: oSTB=oCYC=0; if read, latch iDAT to oRspDat, else oRspDat=0; oRspErr=0; go RESP.
- BUS timeout: counter increments every BUS cycle without iACK; on the edge where counter == TIMEOUT_CYC-1 and iACK=0: oSTB=oCYC=0, oRspDat=ERR_RDATA, oRspErr=1, go RESP.
- iACK and timeout expiry on the same edge: iACK wins (normal completion, oRspErr=0).
- RESP: oRspValid=1 for exactly one cycle; unconditionally return to IDLE. No backpressure on responses.
- iACK while not in BUS: ignored, no state change.
- iCmd* changes while not accepted: no effect on bus outputs.
- oWE, oADR, oDAT, oSEL retain last values after cycle ends; only oSTB/oCYC qualify them.
- Counter: 16 bits, saturating, cleared on accept.

## Timing
- Reset values (edge with iRSTn=0): state IDLE, oCmdReady=1, oSTB=oCYC=oWE=0, oADR=oDAT=0, oSEL=0, oRspValid=0, oRspDat=0, oRspErr=0, counter=0.
- Reset mid-operation: oSTB/oCYC fall at the reset edge; no oRspValid is produced for the aborted command.
- Accept at edge N -> oSTB/oCYC high from N.
- iACK sampled at edge N+k (k>=1) -> oSTB low and oRspValid high from N+k; oCmdReady high from N+k+1.
- Minimum command-to-command spacing: 3 cycles (zero-wait responder).
- Timeout: accept at edge N, no iACK -> abort at edge N+TIMEOUT_CYC; oRspValid/oRspErr high for cycle N+TIMEOUT_CYC.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: timeout counter and abort path as above.
- Not defined: counter and abort logic removed; BUS waits for iACK indefinitely; oRspErr tied 0; TIMEOUT_CYC and ERR_RDATA unused.

## Test plan
- Write 0x0200_0104 data 0xA5A5_0001 sel 4'hF, responder acks 1 cycle after oSTB -> oWE=1, oADR/oDAT stable while oSTB=1, single oRspValid with oRspErr=0, oRspDat=0.
- Read 0x0200_0800, responder acks after 3 wait cycles with iDAT=0x0000_00C3 -> oRspDat=0x0000_00C3, oRspErr=0, oSTB high exactly 4 cycles.
- Read unmapped 0x0300_0000, no iACK, TIMEOUT_CYC=16 -> oSTB/oCYC drop 16 cycles after accept, oRspErr=1, oRspDat=ERR_RDATA; without BUS_MASTER_TIMEOUT_EN oSTB stays high for 100+ cycles.
- iACK asserted on the exact timeout edge -> normal completion, oRspErr=0, captured iDAT returned.
- iRSTn low for one cycle during BUS -> oSTB/oCYC low next cycle, no oRspValid, oCmdReady=1; next command completes normally.
- Back-to-back commands with iCmdValid held high, zero-wait responder -> one accept every 3 cycles, responses in order, spurious iACK in IDLE ignored.
